rat_io_responder: RTL and testbench

Port-bus responder on the peripheral side of the RAT MCU. It sits on the MCU's PORT_ID / OUT_PORT / IO_STRB bus and drives the MCU's IN_PORT and INTR inputs. It decodes output writes into LED, seven-segment and interrupt-control registers, and multiplexes switches, debounced buttons and interrupt status onto the MCU's input port. It debounces push-buttons and raises a level interrupt on debounced press edges. The interrupt is held until software acknowledges it.

---
 rtl/rat_io_responder.sv | 119 +++++++++++
 tb/tb_rat_io_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rat_io_responder.sv
// RAT MCU port-bus responder: LED/7-seg/IRQ registers, switch and button
// inputs, debounced press interrupts. Build option: IO_READBACK_EN.
module rat_io_responder #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  input  logic [7:0]       SWITCHES,
  input  logic [N_BTN-1:0] BUTTONS,
  output logic [7:0]       IN_PORT,
  output logic             INTR,
  output logic [7:0]       LEDS,
  output logic [7:0]       SSEG_DATA,
  output logic [N_BTN-1:0] BTN_DB
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [7:0] ID_LEDS = 8'h40;
  localparam logic [7:0] ID_SSEG = 8'h81;
  localparam logic [7:0] ID_ACK  = 8'h82;
  localparam logic [7:0] ID_MASK = 8'h83;
  localparam logic [7:0] ID_SW   = 8'h20;
  localparam logic [7:0] ID_BTN  = 8'h24;
  localparam logic [7:0] ID_PEND = 8'h25;
  localparam logic [7:0] ID_RMSK = 8'h26;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] ack;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] irq_mask;
  logic [CW-1:0]    cnt [N_BTN];

  logic wr_leds;
  logic wr_sseg;
  logic wr_ack;
  logic wr_mask;

  assign wr_leds = IO_STRB && (PORT_ID == ID_LEDS);
  assign wr_sseg = IO_STRB && (PORT_ID == ID_SSEG);
  assign wr_ack  = IO_STRB && (PORT_ID == ID_ACK);
  assign wr_mask = IO_STRB && (PORT_ID == ID_MASK);
  assign ack     = wr_ack ? OUT_PORT[N_BTN-1:0] : '0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= BUTTONS;
      sync2 <= sync1;
    end
  end

  // A press is accepted on the same edge the debounced level goes high.
  always_comb begin
    rise = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rise[i] = ~BTN_DB[i] & sync2[i] & (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      BTN_DB <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2[i] == BTN_DB[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          BTN_DB[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      LEDS      <= '0;
      SSEG_DATA <= '0;
      irq_mask  <= '0;
      pending   <= '0;
      INTR      <= 1'b0;
    end else begin
      if (wr_leds) LEDS <= OUT_PORT;
      if (wr_sseg) SSEG_DATA <= OUT_PORT;
      if (wr_mask) irq_mask <= OUT_PORT[N_BTN-1:0];
      pending <= (pending & ~ack) | rise;
      INTR    <= |(pending & irq_mask);
    end
  end

  always_comb begin
    IN_PORT = 8'h00;
    unique case (PORT_ID)
      ID_SW:   IN_PORT = SWITCHES;
      ID_BTN:  IN_PORT = 8'(BTN_DB);
      ID_PEND: IN_PORT = 8'(pending);
      ID_RMSK: IN_PORT = 8'(irq_mask);
`ifdef IO_READBACK_EN
      ID_LEDS: IN_PORT = LEDS;
      ID_SSEG: IN_PORT = SSEG_DATA;
`endif
      default: IN_PORT = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_rat_io_responder.sv
// Testbench for rat_io_responder: vector table, directed button
// sequences and randomized traffic against a behavioural model.
module tb_rat_io_responder;

  localparam int N  = 4;
  localparam int DC = 16;
`ifdef IO_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   id;
  logic [7:0]   data;
  logic         strb;
  logic [7:0]   sw;
  logic [N-1:0] btn;
  logic [7:0]   in_port;
  logic         intr;
  logic [7:0]   leds;
  logic [7:0]   sseg;
  logic [N-1:0] db;

  int n_chk  = 0;
  int n_fail = 0;

  rat_io_responder #(.N_BTN(N), .DEBOUNCE_CYCLES(DC)) dut (
    .CLK(clk), .RESET(rst), .PORT_ID(id), .OUT_PORT(data),
    .IO_STRB(strb), .SWITCHES(sw), .BUTTONS(btn), .IN_PORT(in_port),
    .INTR(intr), .LEDS(leds), .SSEG_DATA(sseg), .BTN_DB(db)
  );

  always #5 clk = ~clk;

  // Behavioural model: buttons seen two cycles late, accepted after DC
  // identical consecutive samples that differ from the debounced level.
  logic [7:0]   m_leds, m_sseg;
  logic [N-1:0] m_mask, m_pend, m_db, dl0, dl1, last;
  logic         m_intr;
  int           run [N];

  always @(posedge clk) begin
    logic [N-1:0] set, clr, op, om;
    if (rst) begin
      m_leds = 0; m_sseg = 0; m_mask = 0; m_pend = 0; m_db = 0;
      m_intr = 0; dl0 = 0; dl1 = 0; last = 0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end else begin
      op = m_pend;
      om = m_mask;
      m_intr = |(op & om);
      set = 0;
      for (int i = 0; i < N; i++) begin
        if (dl1[i] == last[i]) run[i]++;
        else begin
          run[i] = 1;
          last[i] = dl1[i];
        end
        if (dl1[i] != m_db[i] && run[i] >= DC) begin
          m_db[i] = dl1[i];
          if (dl1[i]) set[i] = 1'b1;
        end
      end
      dl1 = dl0;
      dl0 = btn;
      clr = (strb && id == 8'h82) ? data[N-1:0] : '0;
      m_pend = (op & ~clr) | set;
      if (strb && id == 8'h40) m_leds = data;
      if (strb && id == 8'h81) m_sseg = data;
      if (strb && id == 8'h83) m_mask = data[N-1:0];
    end
  end

  function automatic logic [7:0] m_read(logic [7:0] a);
    case (a)
      8'h20:   return sw;
      8'h24:   return 8'(m_db);
      8'h25:   return 8'(m_pend);
      8'h26:   return 8'(m_mask);
      8'h40:   return RB ? m_leds : 8'h00;
      8'h81:   return RB ? m_sseg : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] rb(logic [7:0] v);
    return RB ? v : 8'h00;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("model_leds", 32'(leds), 32'(m_leds));
    chk("model_sseg", 32'(sseg), 32'(m_sseg));
    chk("model_btn_db", 32'(db), 32'(m_db));
    chk("model_intr", 32'(intr), 32'(m_intr));
    chk("model_in_port", 32'(in_port), 32'(m_read(id)));
  endtask

  task automatic tick(int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic drive(logic s, logic [7:0] a, logic [7:0] d);
    strb = s;
    id   = a;
    data = d;
  endtask

  typedef struct {
    logic       s;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] sw;
    logic [7:0] exp_in;
    logic [7:0] exp_leds;
    logic [7:0] exp_sseg;
  } vec_t;

  vec_t vt [16];

  initial begin
    vt[0]  = '{1, 8'h40, 8'hA5, 8'h00, 8'h00,      8'hA5, 8'h00};
    vt[1]  = '{0, 8'h40, 8'h11, 8'h00, rb(8'hA5),  8'hA5, 8'h00};
    vt[2]  = '{0, 8'h20, 8'h00, 8'h3C, 8'h3C,      8'hA5, 8'h00};
    vt[3]  = '{0, 8'h99, 8'h00, 8'h3C, 8'h00,      8'hA5, 8'h00};
    vt[4]  = '{1, 8'h81, 8'h77, 8'h3C, 8'h00,      8'hA5, 8'h77};
    vt[5]  = '{1, 8'h40, 8'h5A, 8'h3C, rb(8'hA5),  8'h5A, 8'h77};
    vt[6]  = '{0, 8'h40, 8'h00, 8'h3C, rb(8'h5A),  8'h5A, 8'h77};
    vt[7]  = '{0, 8'h81, 8'h00, 8'h3C, rb(8'h77),  8'h5A, 8'h77};
    vt[8]  = '{1, 8'h41, 8'hFF, 8'h3C, 8'h00,      8'h5A, 8'h77};
    vt[9]  = '{1, 8'h83, 8'hF3, 8'h3C, 8'h00,      8'h5A, 8'h77};
    vt[10] = '{0, 8'h26, 8'h00, 8'h3C, 8'h03,      8'h5A, 8'h77};
    vt[11] = '{0, 8'h24, 8'h00, 8'h3C, 8'h01,      8'h5A, 8'h77};
    vt[12] = '{0, 8'h25, 8'h00, 8'h3C, 8'h01,      8'h5A, 8'h77};
    vt[13] = '{1, 8'h83, 8'h00, 8'h3C, 8'h00,      8'h5A, 8'h77};
    vt[14] = '{1, 8'h82, 8'h01, 8'h3C, 8'h00,      8'h5A, 8'h77};
    vt[15] = '{0, 8'h25, 8'h00, 8'h3C, 8'h00,      8'h5A, 8'h77};

    rst = 1'b1;
    btn = '1;
    sw  = 8'h00;
    drive(0, 8'h25, 8'h00);
    tick(3);
    chk("reset_leds", 32'(leds), 0);
    chk("reset_sseg", 32'(sseg), 0);
    chk("reset_btn_db", 32'(db), 0);
    chk("reset_intr", 32'(intr), 0);
    chk("reset_in_port", 32'(in_port), 0);

    btn = 4'b0001;
    rst = 1'b0;
    tick(DC + 1);
    chk("rst_db_early", 32'(db[0]), 0);
    tick();
    chk("rst_db_on_time", 32'(db[0]), 1);
    chk("rst_pending", 32'(in_port), 1);

    for (int v = 0; v < 16; v++) begin
      drive(vt[v].s, vt[v].a, vt[v].d);
      sw = vt[v].sw;
      #1;
      chk($sformatf("vec%0d_in_port", v), 32'(in_port), 32'(vt[v].exp_in));
      tick();
      chk($sformatf("vec%0d_leds", v), 32'(leds), 32'(vt[v].exp_leds));
      chk($sformatf("vec%0d_sseg", v), 32'(sseg), 32'(vt[v].exp_sseg));
    end

    btn = '0;
    drive(0, 8'h25, 8'h00);
    tick(40);
    chk("release_no_pend", 32'(in_port), 0);
    drive(1, 8'h83, 8'h01);
    tick();
    drive(0, 8'h25, 8'h00);
    btn = 4'b0001;
    tick(3);
    btn = '0;
    tick(30);
    chk("glitch_db", 32'(db), 0);
    chk("glitch_intr", 32'(intr), 0);
    chk("glitch_pend", 32'(in_port), 0);

    btn = 4'b0001;
    tick(DC + 1);
    chk("press_db_early", 32'(db[0]), 0);
    tick();
    chk("press_db", 32'(db[0]), 1);
    chk("press_pend", 32'(in_port), 1);
    chk("press_intr_lag", 32'(intr), 0);
    tick();
    chk("press_intr", 32'(intr), 1);
    tick(20);
    chk("hold_pend", 32'(in_port), 1);
    chk("hold_intr", 32'(intr), 1);

    drive(1, 8'h82, 8'h01);
    tick();
    drive(0, 8'h25, 8'h00);
    #1;
    chk("ack_pend", 32'(in_port), 0);
    tick();
    chk("ack_intr", 32'(intr), 0);
    btn = '0;
    tick(40);
    chk("rel_intr", 32'(intr), 0);
    btn = 4'b0001;
    tick(40);
    chk("repress_intr", 32'(intr), 1);

    btn = 4'b0011;
    tick(DC + 1);
    drive(1, 8'h82, 8'h02);
    tick();
    drive(0, 8'h25, 8'h00);
    #1;
    chk("setwins_pend", 32'(in_port), 8'h03);
    chk("setwins_db", 32'(db), 4'b0011);

    for (int c = 0; c < 3000; c++) begin
      logic [7:0] ids [9];
      ids = '{8'h40, 8'h81, 8'h82, 8'h83, 8'h20, 8'h24, 8'h25, 8'h26, 8'h00};
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 39) == 0) btn[i] = ~btn[i];
      if ($urandom_range(0, 19) == 0) sw = 8'($urandom);
      ids[8] = 8'($urandom);
      drive($urandom_range(0, 3) == 0, ids[$urandom_range(0, 8)],
            8'($urandom));
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
